fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Program-counter and fetch controller for the 16-bit CPU's 32x16 combinational instruction memory. Drives the memory address, latches the returned word into an instruction register and hands it to the execute datapath with a valid/ack handshake. Resolves unconditional `jump` locally; accepts datapath redirects (compare-based branches). Supports halt-at-end-of-program or wrap-around.

Parameters:
ADDR_W, 5, instruction address width (32 words)
INSTR_W, 16, instruction width
LAST_ADR, 19, address of the final program word
WRAP, 0, 1 = continue at address 0 after LAST_ADR; 0 = halt
OP_JUMP, 5'b10010, opcode of unconditional jump

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  leave IDLE and begin fetching at pc
instruction  in  16  word returned combinationally by instruction memory
instruction_adr  out  5  address to instruction memory
ir  out  16  latched instruction presented to execute
ir_valid  out  1  ir holds an issued, not yet accepted instruction
exec_ack  in  1  execute has consumed ir (sampled only when ir_valid=1)
redirect_valid  in  1  take redirect_adr as next pc (sampled only with exec_ack)
redirect_adr  in  5  branch target from datapath
pc  out  5  current program counter
halted  out  1  sequencer in HALT
retired  out  16  count of acknowledged instructions, saturating at 16'hFFFF

Behaviour:
- Reset (rst=1 at edge): state=IDLE, pc=0, ir=16'h0000, ir_valid=0, halted=0, retired=0; rst overrides everything, including mid-handshake and HALT.
- instruction_adr = pc combinationally in every state; memory word is valid the same cycle.
- Field decode: opcode = instruction[15:11]; jump target = instruction[10:6].
- IDLE: start=1 -> FETCH next cycle; otherwise remain.
- FETCH (one cycle): at edge, ir <= instruction.
  - opcode == OP_JUMP: pc <= instruction[10:6]; remain in FETCH; ir_valid stays 0; retired unchanged. Jump costs exactly 1 cycle, never issued. Jump-to-self loops forever (legal, no detection).
  - otherwise: -> ISSUE; ir_valid=1 from next cycle.
- ISSUE: ir and ir_valid held stable until exec_ack=1. On the exec_ack edge: ir_valid <= 0, retired <= retired+1 (saturating), then next pc:
  - redirect_valid=1: pc <= redirect_adr -> FETCH (highest priority, even when pc==LAST_ADR).
  - pc==LAST_ADR and WRAP=1: pc <= 0 -> FETCH.
  - pc==LAST_ADR and WRAP=0: -> HALT, pc unchanged.
  - else pc <= pc+1 (5-bit, wraps 31->0 naturally) -> FETCH.
- Minimum throughput: 2 cycles per non-jump instruction (FETCH + ISSUE with immediate ack).
- HALT: halted=1, ir_valid=0, pc frozen, start ignored; exit only via rst.
- start asserted outside IDLE: ignored. redirect_valid without exec_ack: ignored.
- nop (opcode 00000) is issued and retired like any other instruction.

Decomposition:
- Shared package/header: ADDR_W, INSTR_W, opcode constants (OP_JUMP, OP_NOP), state encoding IDLE/FETCH/ISSUE/HALT (2 bits), field-slice constants for opcode and jump target.
- No sub-module; a single FSM plus pc/ir/retired registers. Bench instantiates it alongside InstructionMem.

Test Plan:
- Reset then start, straight-line program at 0..3 with exec_ack one cycle after each ir_valid -> instruction_adr sequence 0,1,2,3; ir matches Mem[n]; retired=4 after fourth ack; 2 cycles per instruction.
- Mem[5] = jump to 2 -> after FETCH at pc=5, next instruction_adr=2 with ir_valid never raised for word 5; retired unchanged by the jump.
- Hold exec_ack low 5 cycles in ISSUE -> ir and ir_valid stable all 5 cycles, pc unchanged; ack -> pc+1.
- exec_ack with redirect_valid=1, redirect_adr=14 at pc=7 -> next instruction_adr=14; redirect at pc=LAST_ADR=19 overrides halt.
- WRAP=0, ack at pc=19 -> halted=1, ir_valid=0, start pulses ignored; WRAP=1 -> next fetch at address 0.
- rst asserted during ISSUE with ir_valid=1 -> next cycle pc=0, ir=0, ir_valid=0, retired=0, state IDLE.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    // Default geometry of the instruction memory and program.
    localparam int FS_ADDR_W   = 5;
    localparam int FS_INSTR_W  = 16;
    localparam int FS_OPC_W    = 5;
    localparam int FS_LAST_ADR = 19;

    // Instruction field slices: opcode in the top five bits, jump target just below.
    localparam int FS_OPC_MSB = 15;
    localparam int FS_OPC_LSB = 11;
    localparam int FS_TGT_MSB = 10;
    localparam int FS_TGT_LSB = 6;

    // Opcodes the sequencer needs to recognise.
    localparam logic [FS_OPC_W-1:0] FS_OP_JUMP = 5'b10010;
    localparam logic [FS_OPC_W-1:0] FS_OP_NOP  = 5'b00000;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fs_state_e;

    // Retired-instruction counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: addresses the instruction memory,
// latches the returned word, resolves unconditional jumps locally and hands
// every other instruction to execute over a valid/ack handshake.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                  ADDR_W   = FS_ADDR_W,
    parameter int                  INSTR_W  = FS_INSTR_W,
    parameter int                  LAST_ADR = FS_LAST_ADR,
    parameter bit                  WRAP     = 1'b0,
    parameter logic [FS_OPC_W-1:0] OP_JUMP  = FS_OP_JUMP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instruction_adr,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               exec_ack,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_adr,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic [15:0]        retired
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADR);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    fs_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic [15:0]        retired_q, retired_d;

    logic [FS_OPC_W-1:0] opcode;
    logic [ADDR_W-1:0]   jump_target;
    logic                is_jump;
    logic                at_last;

    // Decode the word currently returned by memory for the address in pc.
    always_comb begin
        opcode      = instruction[FS_OPC_MSB:FS_OPC_LSB];
        jump_target = instruction[FS_TGT_MSB:FS_TGT_LSB];
        is_jump     = (opcode == OP_JUMP);
        at_last     = (pc_q == LAST_PC);
    end

    // Next-state and datapath update; every register holds unless a state moves it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        retired_d  = retired_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                ir_d = instruction;
                if (is_jump) begin
                    // Jumps are consumed here and never reach execute; a jump to
                    // itself simply refetches the same word forever.
                    pc_d = jump_target;
                end else begin
                    state_d    = ST_ISSUE;
                    ir_valid_d = 1'b1;
                end
            end

            ST_ISSUE: begin
                if (exec_ack) begin
                    ir_valid_d = 1'b0;
                    retired_d  = sat_inc16(retired_q);
                    if (redirect_valid) begin
                        // A taken branch wins even on the final program word.
                        pc_d    = redirect_adr;
                        state_d = ST_FETCH;
                    end else if (at_last) begin
                        if (WRAP) begin
                            pc_d    = '0;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_HALT;
                        end
                    end else begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_HALT: begin
                ir_valid_d = 1'b0;
            end

            default: begin
                state_d    = ST_IDLE;
                ir_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including ir.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            retired_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            retired_q  <= retired_d;
        end
    end

    // Memory is combinational, so the address is simply the current pc.
    always_comb begin
        instruction_adr = pc_q;
        pc              = pc_q;
        ir              = ir_q;
        ir_valid        = ir_valid_q;
        halted          = (state_q == ST_HALT);
        retired         = retired_q;
    end

endmodule
